// File: rtl/pipeline2_xy_packer.sv
// Captures pipeline2 X/Y results aligned to their issue, packs pairs into words,
// and queues the words in a ready/valid FIFO with saturating ones counters.
module pipeline2_xy_packer #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned WORD_PAIRS = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic                        x_in,
    input  logic                        y_in,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WORD_PAIRS-1:0]     out_data,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [CNT_W-1:0]            x_count,
    output logic [CNT_W-1:0]            y_count,
    output logic                        overflow
);

    localparam int unsigned WORD_W = 2 * WORD_PAIRS;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = (WORD_PAIRS > 1) ? $clog2(WORD_PAIRS) : 1;

    logic [LATENCY-1:0] dly_q, dly_d;
    logic [IDX_W-1:0]   pair_idx_q, pair_idx_d;
    logic [WORD_W-1:0]  partial_q, partial_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_d;
    logic [CNT_W-1:0]   x_count_d, y_count_d;
    logic               overflow_d;
    logic [WORD_W-1:0]  mem [DEPTH];

    logic               cap_c;
    logic               last_c;
    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               wr_en_c;
    logic [WORD_W-1:0]  word_c;

    assign cap_c  = dly_q[LATENCY-1];
    assign last_c = (pair_idx_q == IDX_W'(WORD_PAIRS - 1));
    assign push_c = cap_c && last_c;
    assign pop_c  = (fifo_level != '0) && out_ready;
    assign full_c = (fifo_level == LVL_W'(DEPTH));

    // Head word straight from storage; empty reads as zero
    assign out_data = out_valid ? mem[rd_ptr_q] : '0;

    // Partial word with the current X/Y pair dropped into its slot
    always_comb begin
        word_c = partial_q;
        for (int unsigned i = 0; i < WORD_PAIRS; i++) begin
            if (pair_idx_q == IDX_W'(i)) begin
                word_c[2*i +: 2] = {x_in, y_in};
            end
        end
    end

    // Next-state for delay line, packer, counters and FIFO bookkeeping
    always_comb begin
        dly_d      = '0;
        pair_idx_d = pair_idx_q;
        partial_d  = partial_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = fifo_level;
        x_count_d  = x_count;
        y_count_d  = y_count;
        overflow_d = overflow;
        wr_en_c    = 1'b0;

        if (flush) begin
            pair_idx_d = '0;
            partial_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            x_count_d  = '0;
            y_count_d  = '0;
            overflow_d = 1'b0;
        end else begin
            dly_d[0] = issue_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dly_d[i] = dly_q[i-1];
            end

            if (cap_c) begin
                if (x_in && (x_count != '1)) x_count_d = x_count + CNT_W'(1);
                if (y_in && (y_count != '1)) y_count_d = y_count + CNT_W'(1);
                if (last_c) begin
                    pair_idx_d = '0;
                    partial_d  = '0;
                end else begin
                    pair_idx_d = pair_idx_q + IDX_W'(1);
                    partial_d  = word_c;
                end
            end

            // A pop on the same edge frees the slot a full FIFO needs
            wr_en_c = push_c && (!full_c || pop_c);
            if (push_c && full_c && !pop_c) overflow_d = 1'b1;
            if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

            case ({wr_en_c, pop_c})
                2'b10:   level_d = fifo_level + LVL_W'(1);
                2'b01:   level_d = fifo_level - LVL_W'(1);
                default: level_d = fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q      <= '0;
            pair_idx_q <= '0;
            partial_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            x_count    <= '0;
            y_count    <= '0;
            overflow   <= 1'b0;
        end else begin
            dly_q      <= dly_d;
            pair_idx_q <= pair_idx_d;
            partial_q  <= partial_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_level <= level_d;
            out_valid  <= (level_d != '0);
            x_count    <= x_count_d;
            y_count    <= y_count_d;
            overflow   <= overflow_d;
        end
    end

    // Storage needs no reset: level and out_valid gate every read
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q] <= word_c;
        end
    end

endmodule

// File: tb/tb_pipeline2_xy_packer.sv
// Directed bench for pipeline2_xy_packer: alignment, gaps, reset, full FIFO,
// full-with-pop, flush and counter saturation.
module tb_pipeline2_xy_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic       x_in;
    logic       y_in;
    logic       flush;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] fifo_level;
    logic [15:0] x_count;
    logic [15:0] y_count;
    logic       overflow;

    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic [2:0] s_fifo_level;
    logic [1:0] s_x_count;
    logic [1:0] s_y_count;
    logic       s_overflow;

    int checks = 0;
    int errors = 0;

    logic [2:0] pv, px, py;
    logic [7:0] words [5];

    always #5 clk = ~clk;

    pipeline2_xy_packer dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .x_in(x_in), .y_in(y_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .x_count(x_count), .y_count(y_count), .overflow(overflow)
    );

    pipeline2_xy_packer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .x_in(x_in), .y_in(y_in),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .fifo_level(s_fifo_level), .x_count(s_x_count), .y_count(s_y_count),
        .overflow(s_overflow)
    );

    // One cycle of upstream traffic; results appear on X/Y three cycles after issue,
    // idle cycles carry X=Y=1 garbage
    task automatic drive(input logic iv, input logic xv, input logic yv);
        issue_valid = iv;
        if (pv[2]) begin
            x_in = px[2];
            y_in = py[2];
        end else begin
            x_in = 1'b1;
            y_in = 1'b1;
        end
        pv = {pv[1:0], iv};
        px = {px[1:0], xv};
        py = {py[1:0], yv};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        pv = '0;
    endtask

    task automatic issue_word(input logic [7:0] w);
        for (int i = 0; i < 4; i++) drive(1'b1, w[2*i+1], w[2*i]);
    endtask

    task automatic test_reset_state();
        checks++;
        if ({out_valid, out_data, fifo_level, x_count, y_count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h level=%0d x=%0d y=%0d ovf=%b",
                     out_valid, out_data, fifo_level, x_count, y_count, overflow);
        end
    endtask

    task automatic test_alignment();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL align_early: out_valid=%b expected 0", out_valid);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL align_valid: out_valid=%b expected 1", out_valid);
        end
        checks++;
        if (out_data !== 8'b00_11_01_10) begin
            errors++; $display("FAIL align_data: got %h expected %h", out_data, 8'b00_11_01_10);
        end
        checks++;
        if (x_count !== 16'd2 || y_count !== 16'd2) begin
            errors++; $display("FAIL align_counts: x=%0d y=%0d expected 2 2", x_count, y_count);
        end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL align_pop: valid=%b level=%0d data=%h expected 0 0 00",
                     out_valid, fifo_level, out_data);
        end
    endtask

    task automatic test_gaps();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        idle(4);
        checks++;
        if (fifo_level !== 3'd1 || out_data !== 8'hC9) begin
            errors++;
            $display("FAIL gaps_word: level=%0d data=%h expected 1 c9", fifo_level, out_data);
        end
        checks++;
        if (x_count !== 16'd4 || y_count !== 16'd4) begin
            errors++; $display("FAIL gaps_counts: x=%0d y=%0d expected 4 4", x_count, y_count);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, fifo_level, x_count, y_count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%h level=%0d x=%0d y=%0d ovf=%b",
                     out_valid, out_data, fifo_level, x_count, y_count, overflow);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        checks++;
        if (fifo_level !== 3'd0 || x_count !== 16'd0 || y_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_inflight: level=%0d x=%0d y=%0d expected 0 0 0",
                     fifo_level, x_count, y_count);
        end
        pv = '0;
    endtask

    task automatic test_full();
        do_flush();
        out_ready = 1'b0;
        for (int w = 0; w < 5; w++) issue_word(words[w]);
        idle(3);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_state: level=%0d ovf=%b expected 4 1", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== words[w]) begin
                errors++;
                $display("FAIL full_drain%0d: valid=%b data=%h expected 1 %h",
                         w, out_valid, out_data, words[w]);
            end
            idle(1);
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL full_fifth: valid=%b level=%0d expected 0 0", out_valid, fifo_level);
        end
        idle(1);
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_flush();
        for (int w = 0; w < 4; w++) issue_word(words[w]);
        idle(3);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_fill: level=%0d ovf=%b expected 4 0", fifo_level, overflow);
        end
        issue_word(words[4]);
        idle(2);
        out_ready = 1'b1;
        checks++;
        if (out_data !== words[0]) begin
            errors++; $display("FAIL fullpop_head: got %h expected %h", out_data, words[0]);
        end
        idle(1);
        out_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_level: level=%0d ovf=%b expected 4 0", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int w = 1; w < 5; w++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== words[w]) begin
                errors++;
                $display("FAIL fullpop_drain%0d: valid=%b data=%h expected 1 %h",
                         w, out_valid, out_data, words[w]);
            end
            idle(1);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush_saturate();
        do_flush();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (s_x_count !== 2'd3 || x_count !== 16'd5) begin
            errors++;
            $display("FAIL sat_count: sat_x=%0d x=%0d expected 3 5", s_x_count, x_count);
        end
        checks++;
        if (fifo_level !== 3'd1 || out_data !== 8'hAA) begin
            errors++;
            $display("FAIL sat_word: level=%0d data=%h expected 1 aa", fifo_level, out_data);
        end
        drive(1'b1, 1'b1, 1'b1);
        idle(2);
        flush = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        checks++;
        if ({out_valid, fifo_level, x_count, y_count, overflow, s_x_count} !== '0) begin
            errors++;
            $display("FAIL flush_clear: valid=%b level=%0d x=%0d y=%0d ovf=%b sat_x=%0d",
                     out_valid, fifo_level, x_count, y_count, overflow, s_x_count);
        end
        issue_word(8'h8D);
        idle(3);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h8D) begin
            errors++;
            $display("FAIL flush_next: valid=%b data=%h expected 1 8d", out_valid, out_data);
        end
        checks++;
        if (x_count !== 16'd2 || y_count !== 16'd2 || s_x_count !== 2'd2) begin
            errors++;
            $display("FAIL flush_counts: x=%0d y=%0d sat_x=%0d expected 2 2 2",
                     x_count, y_count, s_x_count);
        end
    endtask

    initial begin
        words[0] = 8'h1B;
        words[1] = 8'hE4;
        words[2] = 8'h5A;
        words[3] = 8'hA5;
        words[4] = 8'h3C;
        pv = '0;
        px = '0;
        py = '0;
        rst_n = 1'b0;
        issue_valid = 1'b0;
        x_in = 1'b0;
        y_in = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_alignment();
        test_gaps();
        test_reset_mid();
        test_full();
        test_full_pop();
        test_flush_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
